// File: rtl/bouncing_square_if.sv
// ---------------------------------------------------------------------------
// bouncing_square_if
//   Bundles the video-path signals of the bouncing_square renderer.
//   master : the timing generator / control side. It drives the pixel
//            coordinates, the frame strobe and the drawing controls, and it
//            observes the colour and status outputs.
//   slave  : the renderer itself.
//   Signals:
//     frame_start        1-cycle pulse at start of vertical blanking
//     mode               00 off, 01 static, 10 bounce, 11 bounce-paused
//     size               square edge length in pixels (0 = nothing drawn)
//     fg_color           {red, green, blue} fill colour
//     x_coords/y_coords  current pixel column / row
//     x_origin/y_origin  top-left corner used in static mode
//     red/green/blue     registered pixel colour
//     sq_x/sq_y          current top-left corner of the square
//     hit                1-cycle pulse on a bounce
//     hit_count          saturating bounce counter
// ---------------------------------------------------------------------------
interface bouncing_square_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 4
);
  logic                   frame_start;
  logic [1:0]             mode;
  logic [COORD_W-1:0]     size;
  logic [3*COLOR_W-1:0]   fg_color;
  logic [COORD_W-1:0]     x_coords;
  logic [COORD_W-1:0]     y_coords;
  logic [COORD_W-1:0]     x_origin;
  logic [COORD_W-1:0]     y_origin;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic [COORD_W-1:0]     sq_x;
  logic [COORD_W-1:0]     sq_y;
  logic                   hit;
  logic [7:0]             hit_count;

  modport master (
    output frame_start, mode, size, fg_color, x_coords, y_coords, x_origin, y_origin,
    input  red, green, blue, sq_x, sq_y, hit, hit_count
  );

  modport slave (
    input  frame_start, mode, size, fg_color, x_coords, y_coords, x_origin, y_origin,
    output red, green, blue, sq_x, sq_y, hit, hit_count
  );
endinterface

// File: rtl/bouncing_square.sv
// ---------------------------------------------------------------------------
// bouncing_square
//   Draws one filled square of run-time size and colour into the pixel stream.
//   The square is either pinned to an origin (static mode) or it moves by STEP
//   pixels per frame on each axis and bounces off the active-area edges.
//   Ports:
//     i_clock  pixel clock; all logic runs on its rising edge
//     i_reset  synchronous, active-high reset
//     bus      bouncing_square_if slave modport (controls, coordinates,
//              colour outputs, position and bounce status)
//   The pixel path has 1 clock of latency. The position only moves in the
//   cycle after frame_start, so a frame never shows two positions.
// ---------------------------------------------------------------------------
module bouncing_square #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 10,
  parameter int STEP     = 2,
  parameter int COLOR_W  = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  bouncing_square_if.slave bus
);

  // Mode encodings. 2'b11 (paused) has no constant of its own: it draws
  // like bounce mode but falls through to the hold-position default.
  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  // Extended width for the position arithmetic. pos+size+STEP can reach
  // about 2*2^COORD_W, so two guard bits keep every sum and difference
  // free of wrap-around.
  localparam int EW = COORD_W + 2;
  localparam logic [EW-1:0] STEP_E = EW'(STEP);

  // -------------------------------------------------------------------------
  // Per-axis position / direction logic: index 0 = x, index 1 = y.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    localparam int LIMIT = (gi == 0) ? H_ACTIVE : V_ACTIVE;
    localparam logic [EW-1:0] LIMIT_E = EW'(LIMIT);

    logic [COORD_W-1:0] r_pos;
    logic               r_dir;        // 1 = moving towards +, 0 = towards -
    logic [COORD_W-1:0] w_coord;
    logic [COORD_W-1:0] w_origin;
    logic [EW-1:0]      w_pos_e;
    logic [EW-1:0]      w_size_e;
    logic [EW-1:0]      w_coord_e;
    logic [EW-1:0]      w_origin_e;
    logic [EW-1:0]      w_room;       // LIMIT - size: the last legal top-left
    logic               w_oversize;
    logic               w_in_range;
    logic [COORD_W-1:0] w_pos_next;
    logic               w_dir_next;
    logic               w_bounce;

    assign w_coord    = (gi == 0) ? bus.x_coords : bus.y_coords;
    assign w_origin   = (gi == 0) ? bus.x_origin : bus.y_origin;
    assign w_pos_e    = EW'(r_pos);
    assign w_size_e   = EW'(bus.size);
    assign w_coord_e  = EW'(w_coord);
    assign w_origin_e = EW'(w_origin);
    assign w_room     = LIMIT_E - w_size_e;
    assign w_oversize = (w_size_e >= LIMIT_E);

    // size = 0 makes this range empty on its own.
    assign w_in_range = (w_coord_e >= w_pos_e) && (w_coord_e < (w_pos_e + w_size_e));

    always_comb begin
      w_pos_next = r_pos;
      w_dir_next = r_dir;
      w_bounce   = 1'b0;
      if (bus.mode == MODE_STATIC) begin
        // w_room is meaningless when oversize. In that case the axis is pinned to 0.
        if (w_oversize) begin
          w_pos_next = '0;
        end else if (w_origin_e > w_room) begin
          w_pos_next = w_room[COORD_W-1:0];
        end else begin
          w_pos_next = w_origin;
        end
      end else if (bus.mode == MODE_BOUNCE) begin
        if (w_oversize) begin
          w_pos_next = '0;
        end else if (r_dir && ((w_pos_e + w_size_e + STEP_E) > LIMIT_E)) begin
          w_pos_next = w_room[COORD_W-1:0];
          w_dir_next = 1'b0;
          w_bounce   = 1'b1;
        end else if (!r_dir && (w_pos_e < STEP_E)) begin
          w_pos_next = '0;
          w_dir_next = 1'b1;
          w_bounce   = 1'b1;
        end else if (r_dir) begin
          w_pos_next = r_pos + COORD_W'(STEP);
        end else begin
          w_pos_next = r_pos - COORD_W'(STEP);
        end
      end
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_pos <= '0;
        r_dir <= 1'b1;
      end else if (bus.frame_start) begin
        r_pos <= w_pos_next;
        r_dir <= w_dir_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bounce reporting and pixel output
  // -------------------------------------------------------------------------
  logic               w_bounce_any;
  logic               w_inside;
  logic               r_hit;
  logic [7:0]         r_hit_count;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;

  // A corner hit bounces both axes at once but counts as a single event.
  assign w_bounce_any = bus.frame_start && (g_axis[0].w_bounce || g_axis[1].w_bounce);
  assign w_inside     = g_axis[0].w_in_range && g_axis[1].w_in_range;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hit       <= 1'b0;
      r_hit_count <= 8'd0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
    end else begin
      r_hit <= w_bounce_any;
      if (w_bounce_any && (r_hit_count != 8'hFF)) begin
        r_hit_count <= r_hit_count + 8'd1;
      end
      if (w_inside && (bus.mode != MODE_OFF)) begin
        {r_red, r_green, r_blue} <= bus.fg_color;
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign bus.red       = r_red;
  assign bus.green     = r_green;
  assign bus.blue      = r_blue;
  assign bus.sq_x      = g_axis[0].r_pos;
  assign bus.sq_y      = g_axis[1].r_pos;
  assign bus.hit       = r_hit;
  assign bus.hit_count = r_hit_count;

endmodule

// File: tb/tb_bouncing_square.sv
// ---------------------------------------------------------------------------
// tb_bouncing_square
//   Directed bench for bouncing_square (640x480, COORD_W=10, STEP=2,
//   COLOR_W=4). The bench drives inputs 1 time unit after a rising edge and
//   samples outputs 1 time unit after the following edge.
// ---------------------------------------------------------------------------
module tb_bouncing_square;
  localparam int CW = 10;
  localparam int KW = 4;
  localparam logic [11:0] FG = 12'hA5C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  bouncing_square_if #(.COORD_W(CW), .COLOR_W(KW)) bus ();

  bouncing_square #(
    .H_ACTIVE(640), .V_ACTIVE(480), .COORD_W(CW), .STEP(2), .COLOR_W(KW)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] %s observed=%0d expected=%0d", $time, tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame_start pulse. hit must show the expected value in the cycle
  // right after the pulse and must be low again in the cycle after that.
  task automatic frame(input string tag, input logic exp_hit);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check({tag, " hit"}, 32'(bus.hit), 32'(exp_hit));
    tick();
    check({tag, " hit_clr"}, 32'(bus.hit), 32'd0);
  endtask

  task automatic pixel(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                       input logic [11:0] exp);
    bus.x_coords = x;
    bus.y_coords = y;
    tick();
    check(tag, 32'({bus.red, bus.green, bus.blue}), 32'(exp));
  endtask

  task automatic pos(input string tag, input int ex, input int ey);
    check({tag, " sq_x"}, 32'(bus.sq_x), 32'(ex));
    check({tag, " sq_y"}, 32'(bus.sq_y), 32'(ey));
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.mode        = 2'b00;
    bus.size        = '0;
    bus.fg_color    = FG;
    bus.x_coords    = '0;
    bus.y_coords    = '0;
    bus.x_origin    = '0;
    bus.y_origin    = '0;

    // Reset state
    tick();
    tick();
    pos("reset", 0, 0);
    check("reset hit", 32'(bus.hit), 32'd0);
    check("reset hit_count", 32'(bus.hit_count), 32'd0);
    check("reset rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    rst = 1'b0;

    // Bounce mode, three frames: 0 -> 2 -> 4 -> 6 on both axes
    bus.mode = 2'b10;
    bus.size = 10'd32;
    frame("b1", 1'b0);
    pos("b1", 2, 2);
    frame("b2", 1'b0);
    frame("b3", 1'b0);
    pos("b3", 6, 6);
    check("b3 hit_count", 32'(bus.hit_count), 32'd0);
    pixel("pix tl",      10'd6,  10'd6,  FG);
    pixel("pix left",    10'd5,  10'd6,  12'd0);
    pixel("pix br",      10'd37, 10'd37, FG);
    pixel("pix right",   10'd38, 10'd20, 12'd0);
    pixel("pix above",   10'd20, 10'd5,  12'd0);
    pixel("pix bottom",  10'd20, 10'd37, FG);
    pixel("pix below",   10'd20, 10'd38, 12'd0);

    // size = 0 draws nothing
    bus.size = 10'd0;
    pixel("size0", 10'd6, 10'd6, 12'd0);
    bus.size = 10'd32;

    // Mode off: black inside the square
    bus.mode = 2'b00;
    pixel("mode off", 10'd10, 10'd10, 12'd0);

    // Paused: five frames, no movement, still drawn
    bus.mode = 2'b11;
    for (int i = 0; i < 5; i++) frame("pause", 1'b0);
    pos("pause", 6, 6);
    pixel("pause draw", 10'd10, 10'd10, FG);

    // Static clamp: min(630,620), min(470,460)
    bus.mode     = 2'b01;
    bus.size     = 10'd20;
    bus.x_origin = 10'd630;
    bus.y_origin = 10'd470;
    frame("static", 1'b0);
    pos("static", 620, 460);
    pixel("clamp out", 10'd619, 10'd460, 12'd0);
    pixel("clamp in",  10'd620, 10'd460, FG);

    // Right/bottom edge: from (607,447), 607+32+2 > 640 and 447+32+2 > 480
    bus.size     = 10'd32;
    bus.x_origin = 10'd607;
    bus.y_origin = 10'd447;
    frame("edge set", 1'b0);
    pos("edge set", 607, 447);
    bus.mode = 2'b10;
    frame("edge bounce", 1'b1);
    pos("edge bounce", 608, 448);
    check("edge hit_count", 32'(bus.hit_count), 32'd1);
    frame("edge back", 1'b0);
    pos("edge back", 606, 446);
    check("edge back hit_count", 32'(bus.hit_count), 32'd1);

    // Corner: (0,0) with both dirs -1 bounces both axes with a single hit
    bus.mode     = 2'b01;
    bus.x_origin = 10'd0;
    bus.y_origin = 10'd0;
    frame("corner set", 1'b0);
    pos("corner set", 0, 0);
    bus.mode = 2'b10;
    frame("corner", 1'b1);
    pos("corner", 0, 0);
    check("corner hit_count", 32'(bus.hit_count), 32'd2);
    frame("corner leave", 1'b0);
    pos("corner leave", 2, 2);

    // Saturation: size 639 bounces x on every frame; y is oversize and pinned
    bus.size = 10'd639;
    for (int i = 0; i < 300; i++) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick();
    end
    check("sat hit_count", 32'(bus.hit_count), 32'd255);
    check("sat sq_y", 32'(bus.sq_y), 32'd0);

    // Reset in the middle of a line while the square is being drawn
    bus.mode     = 2'b01;
    bus.size     = 10'd32;
    bus.x_origin = 10'd100;
    bus.y_origin = 10'd100;
    frame("pre reset", 1'b0);
    pixel("pre reset", 10'd110, 10'd110, FG);
    rst = 1'b1;
    tick();
    check("midreset rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    pos("midreset", 0, 0);
    check("midreset hit_count", 32'(bus.hit_count), 32'd0);
    rst = 1'b0;

    // Directions are back to +1 after reset
    bus.mode = 2'b10;
    frame("post reset", 1'b0);
    pos("post reset", 2, 2);
    pixel("post reset", 10'd2, 10'd2, FG);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
